midi_key_tracker: RTL

- Upstream stage of game_logic: receives the raw MIDI serial line from a PMOD pin and recovers bytes with a UART receiver.
- Parses note-on/note-off messages and maintains the two most relevant held keys.
- Presents the keys as key1_index/key2_index with a one-cycle ready strobe whenever either key changes.
- Runs entirely in the 65 MHz pixel clock domain.

---
 rtl/midi_key_tracker.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/midi_key_tracker.sv
// MIDI front end: UART byte recovery, note-on/off parsing with running status,
// and tracking of the two most relevant held keys for game_logic.
module midi_key_tracker #(
    parameter int         CLKS_PER_BIT = 2080,
    parameter logic [6:0] EMPTY_KEY    = 7'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial,
    output logic [6:0] key1_index,
    output logic [6:0] key2_index,
    output logic       ready,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_error
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    typedef enum logic [1:0] {RUN_NONE, RUN_ON, RUN_OFF} run_t;

    // Returns {slot1, slot2} after applying a note-on/off to the current slots.
    function automatic logic [13:0] next_keys(input logic [6:0] k1, input logic [6:0] k2,
                                              input logic [6:0] n, input logic on);
        logic [6:0] n1;
        logic [6:0] n2;
        n1 = k1;
        n2 = k2;
        if (on) begin
            if (n != k1 && n != k2) begin
                if (k1 == EMPTY_KEY) n1 = n;
                else                 n2 = n;
            end
        end else if (n == k1) begin
            n1 = k2;
            n2 = EMPTY_KEY;
        end else if (n == k2) begin
            n2 = EMPTY_KEY;
        end
        return {n1, n2};
    endfunction

    logic              serial_meta, serial_sync;
    uart_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              armed_q, armed_d;
    logic              byte_ok, byte_bad, expire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            serial_meta <= 1'b1;
            serial_sync <= 1'b1;
        end else begin
            serial_meta <= serial;
            serial_sync <= serial_meta;
        end
    end

    assign expire = (cnt_q <= CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        armed_d   = armed_q | serial_sync;
        byte_ok   = 1'b0;
        byte_bad  = 1'b0;
        if (state_q != IDLE && !expire) cnt_d = cnt_q - CNT_W'(1);
        unique case (state_q)
            IDLE: begin
                // A broken line must return high before another start is accepted.
                if (armed_q && !serial_sync) begin
                    state_d = START;
                    cnt_d   = HALF;
                end
            end
            START: begin
                if (expire) begin
                    if (!serial_sync) begin
                        state_d   = DATA;
                        cnt_d     = FULL;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d   = {serial_sync, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    cnt_d     = FULL;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (expire) begin
                    state_d  = IDLE;
                    byte_ok  = serial_sync;
                    byte_bad = !serial_sync;
                    if (!serial_sync) armed_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            armed_q     <= 1'b1;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
            rx_byte     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            byte_valid  <= byte_ok;
            frame_error <= byte_bad;
            if (byte_ok) rx_byte <= shift_q;
        end
    end

    // Stage p0: message parsing with running status
    run_t       run_q;
    logic       have_note_q;
    logic [6:0] note_q;
    logic       vld_p0, on_p0;
    logic [6:0] note_p0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q       <= RUN_NONE;
            have_note_q <= 1'b0;
            note_q      <= '0;
            vld_p0      <= 1'b0;
            on_p0       <= 1'b0;
            note_p0     <= '0;
        end else begin
            vld_p0 <= 1'b0;
            if (byte_valid && rx_byte < 8'hF8) begin
                if (rx_byte[7]) begin
                    have_note_q <= 1'b0;
                    if (rx_byte[7:4] == 4'h8)      run_q <= RUN_OFF;
                    else if (rx_byte[7:4] == 4'h9) run_q <= RUN_ON;
                    else                           run_q <= RUN_NONE;
                end else if (run_q != RUN_NONE) begin
                    if (!have_note_q) begin
                        note_q      <= rx_byte[6:0];
                        have_note_q <= 1'b1;
                    end else begin
                        have_note_q <= 1'b0;
                        vld_p0      <= 1'b1;
                        on_p0       <= (run_q == RUN_ON) && (rx_byte[6:0] != 7'd0);
                        note_p0     <= note_q;
                    end
                end
            end
        end
    end

    // Stage p1: key slot update and change strobe
    logic [13:0] keys_p1;

    assign keys_p1 = next_keys(key1_index, key2_index, note_p0, on_p0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key1_index <= EMPTY_KEY;
            key2_index <= EMPTY_KEY;
            ready      <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (vld_p0 && note_p0 != EMPTY_KEY) begin
                key1_index <= keys_p1[13:7];
                key2_index <= keys_p1[6:0];
                ready      <= (keys_p1 != {key1_index, key2_index});
            end
        end
    end

endmodule
